keypad_entry_ctrl: RTL and testbench
====================================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd5_000_000; number of idle cycles allowed in ENTRY before the entry is abandoned; 0 disables the timeout.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: key_valid  input  1  key event from the keypad scanner is present this cycle.
REQ-005 Port: key_code  input  4  key identity: 0-9 digit, 4'hA backspace ('*'), 4'hB enter ('#'), 4'hC-4'hF reserved.
REQ-006 Port: key_ready  output  1  controller can accept a key event this cycle.
REQ-007 Port: entry_bcd  output  16  live 4-digit BCD entry, right-aligned, most recent digit in [3:0].
REQ-008 Port: digit_count  output  3  number of digits currently in entry_bcd (0-4).
REQ-009 Port: value_bcd  output  16  committed 4-digit BCD value.
REQ-010 Port: value_valid  output  1  value_bcd is valid and awaiting acknowledge.
REQ-011 Port: value_ack  input  1  consumer acknowledges value_bcd.
REQ-012 Port: err_pulse  output  1  one-cycle pulse: a digit was rejected because the entry was full.
REQ-013 Port: timeout_pulse  output  1  one-cycle pulse: the entry was abandoned by timeout.

Function
REQ-014 The FSM SHALL have states IDLE (digit_count=0), ENTRY (1-4 digits), HOLD (value presented).
REQ-015 key_ready SHALL be 1 in IDLE and ENTRY and 0 in HOLD. A key is accepted only on a cycle where key_valid and key_ready are both 1.
REQ-016 An accepted digit with digit_count<4 SHALL set entry_bcd <= {entry_bcd[11:0], key_code} and increment digit_count, both visible the next cycle. IDLE SHALL go to ENTRY.
REQ-017 An accepted digit with digit_count=4 SHALL leave entry_bcd and digit_count unchanged and assert err_pulse for exactly the next cycle.
REQ-018 An accepted backspace SHALL set entry_bcd <= {4'h0, entry_bcd[15:4]} and decrement digit_count. Reaching 0 SHALL return to IDLE. Backspace in IDLE is a no-op.
REQ-019 An accepted enter in ENTRY SHALL copy entry_bcd to value_bcd, clear entry_bcd and digit_count, and move to HOLD. value_valid SHALL be 1 from the next cycle on.
REQ-020 An accepted enter in IDLE SHALL be consumed with no other effect; no value is produced.
REQ-021 Reserved codes 4'hC-4'hF SHALL be consumed with no state change. They do not restart the timeout counter.
REQ-022 In HOLD, value_valid and value_bcd SHALL stay stable until value_ack=1 is sampled. The next cycle SHALL give value_valid=0 and state IDLE.
REQ-023 value_ack SHALL be ignored outside HOLD.
REQ-024 Timeout counter: cleared on entry to ENTRY and on every accepted digit or backspace; increments each cycle in ENTRY otherwise.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the next edge SHALL clear entry_bcd and digit_count, go to IDLE and assert timeout_pulse for one cycle.
REQ-026 A key accepted on the same cycle as the timeout condition SHALL win: the key is processed, the counter clears and no timeout_pulse is issued.
REQ-027 The timeout counter SHALL be 24 bits, saturate (never wrap) and be inactive in IDLE and HOLD.
REQ-028 All outputs SHALL be registered except key_ready, which is decoded from state.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL go to IDLE and clear entry_bcd, digit_count, value_bcd, value_valid, err_pulse, timeout_pulse and the timeout counter. This holds in any state, including mid-entry and HOLD.
REQ-030 During the reset cycle key_ready SHALL be 1 (IDLE), but no key is accepted while rst_n=0.

Verification
REQ-031 Keys 1,2,3,# with value_ack low -> value_bcd=16'h0123, value_valid=1 held; value_ack=1 for one cycle -> value_valid=0 next cycle, IDLE.
REQ-032 Keys 9,8,7,6,5 -> entry_bcd=16'h9876, digit_count=4, one err_pulse on the 5th key; then * -> entry_bcd=16'h0987, digit_count=3.
REQ-033 TIMEOUT_CYCLES=10, key 4 then no keys -> timeout_pulse exactly 11 cycles after acceptance, entry_bcd=0, IDLE; repeat with key 5 arriving on the expiry cycle -> no pulse, entry_bcd=16'h0045.
REQ-034 In HOLD, key_valid=1 with key 7 -> key_ready=0, entry unchanged. '#' in IDLE and '*' in IDLE -> no value_valid, state stays IDLE.
REQ-035 rst_n=0 for one cycle in HOLD with value_bcd=16'h0042 -> next cycle value_valid=0, value_bcd=0, all outputs at reset values.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to four BCD digits with backspace,
// commits them on enter, and holds the committed value until acknowledged.
// Entries left idle for TIMEOUT_CYCLES cycles are abandoned.
module keypad_entry_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic [15:0] value_bcd,
    output logic        value_valid,
    input  logic        value_ack,
    output logic        err_pulse,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEntry = 2'd1,
        StHold  = 2'd2
    } state_t;

    localparam logic [23:0] CntMax = 24'hFF_FFFF;

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] value_q, value_d;
    logic        vvalid_q, vvalid_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic [23:0] cnt_q, cnt_d;

    logic accept;
    logic is_digit;
    logic is_bs;
    logic is_enter;
    logic timeout_hit;

    // Keys are refused only while a committed value waits for acknowledge.
    assign key_ready = (state_q != StHold);
    assign accept    = key_valid && key_ready;
    assign is_digit  = (key_code <= 4'd9);
    assign is_bs     = (key_code == 4'hA);
    assign is_enter  = (key_code == 4'hB);

    assign timeout_hit = (state_q == StEntry) && (TIMEOUT_CYCLES != 24'd0) &&
                         (cnt_q >= TIMEOUT_CYCLES);

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        count_d  = count_q;
        value_d  = value_q;
        vvalid_d = vvalid_q;
        err_d    = 1'b0;
        tmo_d    = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = 24'd0;
                // Backspace, enter and reserved codes are all consumed silently here.
                if (accept && is_digit) begin
                    entry_d = {entry_q[11:0], key_code};
                    count_d = 3'd1;
                    state_d = StEntry;
                end
            end

            StEntry: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 24'd1;
                end
                // Digit/backspace/enter take priority over an expiring timeout;
                // reserved codes neither restart the counter nor block the timeout.
                if (accept && is_digit) begin
                    cnt_d = 24'd0;
                    if (count_q < 3'd4) begin
                        entry_d = {entry_q[11:0], key_code};
                        count_d = count_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (accept && is_bs) begin
                    cnt_d   = 24'd0;
                    entry_d = {4'h0, entry_q[15:4]};
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end else if (accept && is_enter) begin
                    cnt_d    = 24'd0;
                    value_d  = entry_q;
                    vvalid_d = 1'b1;
                    entry_d  = 16'h0;
                    count_d  = 3'd0;
                    state_d  = StHold;
                end else if (timeout_hit) begin
                    cnt_d   = 24'd0;
                    entry_d = 16'h0;
                    count_d = 3'd0;
                    tmo_d   = 1'b1;
                    state_d = StIdle;
                end
            end

            StHold: begin
                cnt_d = 24'd0;
                if (value_ack) begin
                    vvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            entry_q  <= 16'h0;
            count_q  <= 3'd0;
            value_q  <= 16'h0;
            vvalid_q <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= 24'd0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            value_q  <= value_d;
            vvalid_q <= vvalid_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign entry_bcd     = entry_q;
    assign digit_count   = count_q;
    assign value_bcd     = value_q;
    assign value_valid   = vvalid_q;
    assign err_pulse     = err_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard fed from a digit-list reference model.
module tb_keypad_entry_ctrl;

    localparam logic [23:0] Tmo = 24'd10;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        value_ack;
    logic        err_pulse;
    logic        timeout_pulse;

    keypad_entry_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .entry_bcd     (entry_bcd),
        .digit_count   (digit_count),
        .value_bcd     (value_bcd),
        .value_valid   (value_valid),
        .value_ack     (value_ack),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] entry;
        logic [2:0]  count;
        logic [15:0] value;
        logic        vv;
        logic        err;
        logic        to;
        logic        rdy;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the entry is a list of digits (oldest first).
    int unsigned m_digits[$];
    bit          m_hold;
    logic [15:0] m_value;
    int unsigned m_idle;
    bit          m_err;
    bit          m_to;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits_to_bcd();
        logic [15:0] r = 16'h0;
        foreach (m_digits[i]) r = {r[11:0], m_digits[i][3:0]};
        return r;
    endfunction

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit ack, input bit rstn);
        bit restarted = 0;
        bit was_entry;
        m_err = 0;
        m_to  = 0;
        if (!rstn) begin
            m_digits.delete();
            m_hold  = 0;
            m_value = 16'h0;
            m_idle  = 0;
            return;
        end
        if (m_hold) begin
            if (ack) m_hold = 0;
            return;
        end
        was_entry = (m_digits.size() > 0);
        if (kv && kc <= 4'd9) begin
            restarted = 1;
            if (m_digits.size() < 4) m_digits.push_back(int'(kc));
            else m_err = 1;
        end else if (kv && kc == 4'hA && was_entry) begin
            restarted = 1;
            void'(m_digits.pop_back());
        end else if (kv && kc == 4'hB && was_entry) begin
            m_value = digits_to_bcd();
            m_digits.delete();
            m_hold = 1;
            m_idle = 0;
            return;
        end
        if (was_entry && !restarted && m_idle >= int'(Tmo)) begin
            m_digits.delete();
            m_to = 1;
        end
        // Idle count: cycles in ENTRY since entry began or the last digit/backspace.
        if (!was_entry || restarted) m_idle = 0;
        else m_idle = m_idle + 1;
    endtask

    // Drive one cycle of stimulus and record what the DUT must show after the edge.
    task automatic cycle(input bit kv, input logic [3:0] kc, input bit ack, input bit rstn);
        obs_t e;
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        value_ack = ack;
        rst_n     = rstn;
        model_step(kv, kc, ack, rstn);
        e.entry = digits_to_bcd();
        e.count = 3'(m_digits.size());
        e.value = m_value;
        e.vv    = m_hold;
        e.err   = m_err;
        e.to    = m_to;
        e.rdy   = !m_hold;
        exp_q.push_back(e);
    endtask

    task automatic key(input logic [3:0] kc);
        cycle(1'b1, kc, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every post-edge observation against the scoreboard.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {entry_bcd, digit_count, value_bcd, value_valid, err_pulse,
                     timeout_pulse, key_ready};
                chk("scoreboard", 64'(g), 64'(e));
            end
        end
    end

    initial begin
        int rate;
        key_valid = 0;
        key_code  = 4'h0;
        value_ack = 0;
        rst_n     = 0;
        m_hold    = 0;
        m_value   = 16'h0;
        m_idle    = 0;

        // Reset state
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        settle();
        chk("reset_entry", 64'(entry_bcd), 64'h0);
        chk("reset_vv", 64'(value_valid), 64'h0);
        chk("reset_ready", 64'(key_ready), 64'h1);

        // 1,2,3,# then hold, then acknowledge
        key(4'h1); key(4'h2); key(4'h3); key(4'hB);
        idle(); idle();
        settle();
        chk("commit_value", 64'(value_bcd), 64'h0123);
        chk("commit_vv_held", 64'(value_valid), 64'h1);
        cycle(1'b0, 4'h0, 1'b1, 1'b1);
        settle();
        chk("ack_vv", 64'(value_valid), 64'h0);
        chk("ack_ready", 64'(key_ready), 64'h1);

        // Overflow and backspace
        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
        settle();
        chk("full_err", 64'(err_pulse), 64'h1);
        chk("full_entry", 64'(entry_bcd), 64'h9876);
        chk("full_count", 64'(digit_count), 64'h4);
        key(4'hA);
        settle();
        chk("bs_err_gone", 64'(err_pulse), 64'h0);
        chk("bs_entry", 64'(entry_bcd), 64'h0987);
        chk("bs_count", 64'(digit_count), 64'h3);
        key(4'hA); key(4'hA); key(4'hA);

        // Timeout after 11 cycles
        key(4'h4);
        repeat (10) idle();
        settle();
        chk("tmo_not_early", 64'(timeout_pulse), 64'h0);
        idle();
        settle();
        chk("tmo_pulse", 64'(timeout_pulse), 64'h1);
        chk("tmo_entry", 64'(entry_bcd), 64'h0);

        // Key on the expiry cycle wins
        key(4'h4);
        repeat (10) idle();
        key(4'h5);
        settle();
        chk("tmo_race_pulse", 64'(timeout_pulse), 64'h0);
        chk("tmo_race_entry", 64'(entry_bcd), 64'h0045);
        key(4'hA); key(4'hA);

        // Keys ignored in HOLD, then reset from HOLD
        key(4'h4); key(4'h2); key(4'hB);
        key(4'h7);
        settle();
        chk("hold_ready", 64'(key_ready), 64'h0);
        chk("hold_entry", 64'(entry_bcd), 64'h0);
        chk("hold_value", 64'(value_bcd), 64'h0042);
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        settle();
        chk("rst_hold_vv", 64'(value_valid), 64'h0);
        chk("rst_hold_value", 64'(value_bcd), 64'h0);

        // Enter and backspace in IDLE are no-ops
        key(4'hB); key(4'hA);
        settle();
        chk("idle_keys_vv", 64'(value_valid), 64'h0);
        chk("idle_keys_count", 64'(digit_count), 64'h0);

        // Randomized traffic with varying key density to exercise timeouts
        for (int blk = 0; blk < 60; blk++) begin
            case ($urandom_range(0, 2))
                0: rate = 2;
                1: rate = 8;
                default: rate = 30;
            endcase
            for (int i = 0; i < 50; i++) begin
                logic [3:0] kc;
                if ($urandom_range(0, 9) < 6) kc = 4'($urandom_range(0, 9));
                else kc = 4'($urandom_range(10, 15));
                cycle(($urandom_range(1, rate) == 1), kc, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 299) != 0));
            end
        end

        idle();
        repeat (3) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
